frame_stream_harness: RTL and testbench

Synthesizable stimulus/collection harness for the CINIRD feature pipeline: it holds one grayscale frame in an internal buffer and streams it (optionally repeated, optionally throttled) into the pipeline's pixel input using the frame-valid convention (`done` high while pixels flow). It also counts and checksums the results returned on `N_CH` radius channels, and reports finish, pass and timeout. It replaces file-driven benches for on-board and regression runs.

---
 rtl/frame_stream_harness_if.sv | 15 +
 rtl/frame_stream_harness.sv | 202 ++++++++++++++++++++
 tb/tb_frame_stream_harness.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_stream_harness_if.sv
// Pixel stream leaving the harness and per-channel result strobes returning to it.
// master = harness side, slave = pipeline side.
interface frame_stream_harness_if #(
  parameter int PIX_W = 8,
  parameter int N_CH  = 4,
  parameter int RES_W = 16
);
  logic [PIX_W-1:0]      grayscale_o;
  logic                  done_o;
  logic [N_CH-1:0]       res_valid_i;
  logic [N_CH*RES_W-1:0] res_data_i;

  modport master (output grayscale_o, done_o, input res_valid_i, res_data_i);
  modport slave  (input grayscale_o, done_o, output res_valid_i, res_data_i);
endinterface

// File: rtl/frame_stream_harness.sv
// Frame buffer streamer (done-high-while-valid, optional gap/repeat) plus per-channel
// result counter/checksum with overflow, timeout and pass reporting.
module frame_stream_harness #(
  parameter int COLS    = 30,
  parameter int ROWS    = 30,
  parameter int PIX_W   = 8,
  parameter int N_CH    = 4,
  parameter int RES_W   = 16,
  parameter int CNT_W   = 16,
  parameter int IFG     = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_we_i,
  input  logic [$clog2(COLS*ROWS)-1:0]      load_addr_i,
  input  logic [PIX_W-1:0]                  load_data_i,
  input  logic                              start_i,
  input  logic [7:0]                        frames_i,
  input  logic [3:0]                        gap_i,
  input  logic [N_CH*CNT_W-1:0]             exp_count_i,
  frame_stream_harness_if.master            px,
  output logic                              busy_o,
  output logic                              finish_o,
  output logic                              pass_o,
  output logic                              timeout_o,
  output logic [N_CH-1:0]                   overflow_o,
  output logic [N_CH*CNT_W-1:0]             count_o,
  output logic [N_CH*32-1:0]                checksum_o
);
  localparam int DEPTH   = COLS * ROWS;
  localparam int AW      = $clog2(DEPTH);
  localparam int CYC_MAX = (TIMEOUT > IFG) ? ((TIMEOUT > 15) ? TIMEOUT : 15)
                                           : ((IFG > 15) ? IFG : 15);
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_GAP, S_IFG, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      addr_q, addr_d;
  logic [7:0]         frm_q, frm_d, frames_q, frames_d;
  logic [3:0]         gap_q, gap_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d, cyc_inc;
  logic [CNT_W-1:0]   exp_q [N_CH];
  logic [CNT_W-1:0]   exp_d [N_CH];
  logic [CNT_W-1:0]   cnt_q [N_CH];
  logic [CNT_W-1:0]   cnt_d [N_CH];
  logic [31:0]        sum_q [N_CH];
  logic [31:0]        sum_d [N_CH];
  logic [N_CH-1:0]    ovf_q, ovf_d;
  logic               tmo_q, tmo_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic               vld_q, vld_d;
  logic               busy, all_met, all_eq;

  assign busy    = state_q inside {S_STREAM, S_GAP, S_IFG, S_WAIT};
  assign cyc_inc = cyc_q + 1'b1;

  always_comb begin
    all_met = 1'b1;
    all_eq  = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      if (cnt_q[k] < exp_q[k])  all_met = 1'b0;
      if (cnt_q[k] != exp_q[k]) all_eq  = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    frm_d    = frm_q;
    frames_d = frames_q;
    gap_d    = gap_q;
    cyc_d    = cyc_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;
    pix_d    = pix_q;
    vld_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d  = S_STREAM;
          addr_d   = '0;
          frm_d    = '0;
          frames_d = (frames_i == 8'd0) ? 8'd1 : frames_i;
          gap_d    = gap_i;
          ovf_d    = '0;
          tmo_d    = 1'b0;
          for (int k = 0; k < N_CH; k++) begin
            exp_d[k] = exp_count_i[k*CNT_W +: CNT_W];
            cnt_d[k] = '0;
            sum_d[k] = '0;
          end
        end
      end
      S_STREAM: begin
        pix_d = mem_q[addr_q];
        vld_d = 1'b1;
        cyc_d = '0;
        if (addr_q == AW'(DEPTH - 1)) begin
          // No gap after a frame's last pixel: IFG or result wait follows directly.
          addr_d  = '0;
          frm_d   = frm_q + 8'd1;
          state_d = (frm_q + 8'd1 < frames_q) ? S_IFG : S_WAIT;
        end else begin
          addr_d = addr_q + 1'b1;
          if (gap_q != 4'd0) state_d = S_GAP;
        end
      end
      S_GAP: begin
        cyc_d = cyc_inc;
        if (cyc_inc == CYC_W'(gap_q)) state_d = S_STREAM;
      end
      S_IFG: begin
        cyc_d = cyc_inc;
        if (cyc_inc == CYC_W'(IFG)) state_d = S_STREAM;
      end
      S_WAIT: begin
        cyc_d = cyc_inc;
        if (all_met) begin
          state_d = S_DONE;
        end else if (cyc_inc == CYC_W'(TIMEOUT)) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (busy) begin
      for (int k = 0; k < N_CH; k++) begin
        if (px.res_valid_i[k]) begin
          sum_d[k] = sum_q[k] + 32'(px.res_data_i[k*RES_W +: RES_W]);
          if (cnt_q[k] == exp_q[k])   ovf_d[k] = 1'b1;
          else if (cnt_q[k] != '1)    cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      frm_q    <= '0;
      frames_q <= '0;
      gap_q    <= '0;
      cyc_q    <= '0;
      ovf_q    <= '0;
      tmo_q    <= 1'b0;
      pix_q    <= '0;
      vld_q    <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        exp_q[k] <= '0;
        cnt_q[k] <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      frm_q    <= frm_d;
      frames_q <= frames_d;
      gap_q    <= gap_d;
      cyc_q    <= cyc_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
      pix_q    <= pix_d;
      vld_q    <= vld_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
    end
  end

  // Buffer survives reset so a board run can be restarted without reloading.
  always_ff @(posedge clk) begin
    if (load_we_i && !busy && ({1'b0, load_addr_i} < (AW+1)'(DEPTH)))
      mem_q[load_addr_i] <= load_data_i;
  end

  always_comb begin
    count_o    = '0;
    checksum_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      count_o[k*CNT_W +: CNT_W] = cnt_q[k];
      checksum_o[k*32 +: 32]    = sum_q[k];
    end
  end

  assign px.grayscale_o = pix_q;
  assign px.done_o      = vld_q;
  assign busy_o         = busy;
  assign finish_o       = (state_q == S_DONE);
  assign timeout_o      = tmo_q;
  assign overflow_o     = ovf_q;
  assign pass_o         = (state_q == S_DONE) && !tmo_q && (ovf_q == '0) && all_eq;
endmodule

// File: tb/tb_frame_stream_harness.sv
// Scoreboard bench: stimulus pushes expected pixels (value + cycle) and run outcomes,
// negedge monitors pop and compare whenever done_o is high or finish_o rises.
`timescale 1ns/1ps
module tb_frame_stream_harness;
  localparam int COLS = 4, ROWS = 4, NPIX = 16, PIX_W = 8, N_CH = 4, RES_W = 16;
  localparam int CNT_W = 16, IFG = 16, TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_we_i = 1'b0;
  logic [3:0]    load_addr_i = '0;
  logic [7:0]    load_data_i = '0;
  logic          start_i = 1'b0;
  logic [7:0]    frames_i = '0;
  logic [3:0]    gap_i = '0;
  logic [63:0]   exp_count_i = '0;
  logic          busy_o, finish_o, pass_o, timeout_o;
  logic [3:0]    overflow_o;
  logic [63:0]   count_o;
  logic [127:0]  checksum_o;

  always #5 clk = ~clk;

  frame_stream_harness_if #(.PIX_W(PIX_W), .N_CH(N_CH), .RES_W(RES_W)) px();

  frame_stream_harness #(
    .COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .N_CH(N_CH), .RES_W(RES_W),
    .CNT_W(CNT_W), .IFG(IFG), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .load_we_i(load_we_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
    .start_i(start_i), .frames_i(frames_i), .gap_i(gap_i), .exp_count_i(exp_count_i),
    .px(px),
    .busy_o(busy_o), .finish_o(finish_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .overflow_o(overflow_o), .count_o(count_o), .checksum_o(checksum_o)
  );

  typedef struct packed { int unsigned cyc; logic [7:0] pix; } pix_exp_t;
  typedef struct packed {
    int unsigned  fin;
    logic         pass;
    logic         tmo;
    logic [3:0]   ovf;
    logic [63:0]  cnt;
    logic [127:0] sum;
  } out_exp_t;

  pix_exp_t    pixq[$];
  out_exp_t    outq[$];
  pix_exp_t    pe;
  out_exp_t    oe;
  logic [7:0]  ref_mem [NPIX];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        fin_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (px.done_o === 1'b1) begin
      checks++;
      if (pixq.size() == 0) begin
        errors++;
        $display("FAIL px_unexpected: got pixel %0h at cycle %0d, expected no pixel", px.grayscale_o, cyc);
      end else begin
        checks--;
        pe = pixq.pop_front();
        chk("px_value", px.grayscale_o, pe.pix);
        chk("px_cycle", cyc, pe.cyc);
      end
    end
    if (finish_o === 1'b1 && !fin_prev) begin
      checks++;
      if (outq.size() == 0) begin
        errors++;
        $display("FAIL fin_unexpected: got finish at cycle %0d, expected none", cyc);
      end else begin
        checks--;
        oe = outq.pop_front();
        chk("fin_cycle", cyc, oe.fin);
        chk("pass", pass_o, oe.pass);
        chk("timeout", timeout_o, oe.tmo);
        chk("overflow", overflow_o, oe.ovf);
        chk("count", count_o, oe.cnt);
        chk("checksum", checksum_o, oe.sum);
        chk("busy_in_done", busy_o, 1'b0);
      end
    end
    fin_prev = (finish_o === 1'b1);
  end

  task automatic load_pix(input int a, input logic [7:0] v);
    load_we_i = 1'b1; load_addr_i = 4'(a); load_data_i = v;
    @(posedge clk); #1;
    load_we_i = 1'b0;
    ref_mem[a] = v;
  endtask

  // Issues a start and returns the cycle index of the sampling edge.
  task automatic do_start(input int frames, input int gap, input logic [3:0][15:0] expv,
                          output int unsigned t0);
    int f_eff;
    int unsigned per;
    f_eff = (frames == 0) ? 1 : frames;
    frames_i = 8'(frames); gap_i = 4'(gap); exp_count_i = expv; start_i = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start_i = 1'b0;
    per = (NPIX - 1) * (gap + 1) + 1 + IFG;
    for (int f = 0; f < f_eff; f++)
      for (int j = 0; j < NPIX; j++) begin
        pix_exp_t p;
        p.cyc = t0 + 1 + f * per + j * (gap + 1);
        p.pix = ref_mem[j];
        pixq.push_back(p);
      end
  endtask

  task automatic run_case(input int frames, input int gap, input logic [3:0][15:0] expv,
                          input logic [3:0][7:0] n, input int fixed);
    int unsigned t0, last, per;
    int f_eff;
    logic [3:0][7:0] rem;
    logic [3:0][31:0] sum;
    logic [15:0] d;
    logic met;
    out_exp_t o;
    f_eff = (frames == 0) ? 1 : frames;
    do_start(frames, gap, expv, t0);
    per  = (NPIX - 1) * (gap + 1) + 1 + IFG;
    last = t0 + 1 + (f_eff - 1) * per + (NPIX - 1) * (gap + 1);
    rem = n;
    sum = '0;
    // All strobes land within the first 14 edges, always before the last pixel.
    for (int c = 0; c < 14; c++) begin
      for (int k = 0; k < N_CH; k++) begin
        px.res_valid_i[k] = 1'b0;
        if (rem[k] != 0 && (int'(rem[k]) >= 14 - c || $urandom_range(1, 0) == 1)) begin
          d = (fixed >= 0) ? 16'(fixed) : 16'($urandom);
          px.res_valid_i[k] = 1'b1;
          px.res_data_i[k*16 +: 16] = d;
          sum[k] = sum[k] + 32'(d);
          rem[k] = rem[k] - 8'd1;
        end
      end
      @(posedge clk); #1;
    end
    px.res_valid_i = '0;
    met = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      o.ovf[k] = (16'(n[k]) > expv[k]);
      o.cnt[k*16 +: 16] = o.ovf[k] ? expv[k] : 16'(n[k]);
      if (16'(n[k]) < expv[k]) met = 1'b0;
    end
    o.sum  = sum;
    o.tmo  = !met;
    o.pass = met && (o.ovf == 4'd0);
    o.fin  = met ? last + 1 : last + TIMEOUT;
    outq.push_back(o);
    for (int i = 0; i < 2000 && outq.size() != 0; i++) @(posedge clk);
    #1;
    if (outq.size() != 0) begin
      checks++; errors++;
      $display("FAIL run_wait: finish never seen within 2000 cycles, expected at cycle %0d", o.fin);
      outq.delete();
    end
    chk("px_left", pixq.size(), 0);
    pixq.delete();
  endtask

  initial begin
    logic [3:0][15:0] e4, e8, ex;
    logic [3:0][7:0]  n4, nn;
    int unsigned t0;
    int r;
    px.res_valid_i = '0;
    px.res_data_i  = '0;
    e4 = {4{16'd4}};
    e8 = {4{16'd8}};
    n4 = {4{8'd4}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", px.done_o, 1'b0);
    chk("rst_gray", px.grayscale_o, 8'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_finish", finish_o, 1'b0);
    chk("rst_pass", pass_o, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("rst_overflow", overflow_o, 4'd0);
    chk("rst_count", count_o, 64'd0);
    chk("rst_checksum", checksum_o, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int a = 0; a < NPIX; a++) load_pix(a, 8'(a));

    run_case(1, 0, e4, n4, 5);                         // continuous, checksum 20
    run_case(1, 2, e4, n4, 5);                         // throttled
    run_case(2, 0, e8, {4{8'd8}}, -1);                 // repeated frame with IFG
    run_case(1, 0, e4, {8'd4, 8'd4, 8'd5, 8'd4}, -1);  // overflow on ch1
    run_case(1, 0, e4, {8'd3, 8'd4, 8'd4, 8'd4}, -1);  // timeout on ch3

    // Interrupted run: loads while busy are dropped, reset returns outputs to idle.
    do_start(1, 1, e4, t0);
    for (int i = 0; i < 3; i++) begin
      load_we_i = 1'b1; load_addr_i = 4'(i); load_data_i = 8'hAA;
      px.res_valid_i = 4'b0001; px.res_data_i = 64'h7;
      @(posedge clk); #1;
    end
    load_we_i = 1'b0;
    px.res_valid_i = '0;
    chk("busy_mid_run", busy_o, 1'b1);
    chk("count_mid_run", count_o, 64'd3);
    rst = 1'b1;
    #1;
    chk("mrst_done", px.done_o, 1'b0);
    chk("mrst_gray", px.grayscale_o, 8'd0);
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_count", count_o, 64'd0);
    chk("mrst_checksum", checksum_o, 128'd0);
    pixq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_case(1, 0, e4, n4, 5);                         // buffer retained: 0..15 again

    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < NPIX; a++) load_pix(a, 8'($urandom));
      for (int k = 0; k < N_CH; k++) begin
        ex[k] = 16'($urandom_range(8, 1));
        r = $urandom_range(9, 0);
        nn[k] = (r < 7) ? 8'(ex[k]) : ((r < 8) ? 8'(ex[k] - 16'd1) : 8'(ex[k] + 16'd1));
      end
      run_case($urandom_range(2, 0), $urandom_range(3, 0), ex, nn, -1);
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
